// File: rtl/spi_write_controller.sv
// spi_write_controller
// SPI mode 0 initiator that turns valid/ready write commands into paced
// 16-bit frames {1'b1, addr[6:0], data[7:0]}, sent MSB first on cs_n/sclk/copi.
// Optional feature macro: SPI_CTRL_FIFO_EN adds a FIFO_DEPTH-entry command
// FIFO in front of the frame FSM. Without it, commands are accepted only in IDLE.
module spi_write_controller #(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned GAP_CYCLES = 4
`ifdef SPI_CTRL_FIFO_EN
   ,
   parameter int unsigned FIFO_DEPTH = 4
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [6:0] req_addr,
   input  logic [7:0] req_data,
   output logic       cs_n,
   output logic       sclk,
   output logic       copi,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT_HI,
      SHIFT_LO,
      GAP
   } state_t;

   localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
   localparam logic [7:0] GapLast = 8'(GAP_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  div_q, div_d;
   logic [3:0]  bitCnt_q, bitCnt_d;
   logic [15:0] shiftReg_q, shiftReg_d;
   logic        csN_q, csN_d;
   logic        sclk_q, sclk_d;
   logic        copi_q, copi_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic        start;
   logic [14:0] cmdWord;
   logic        queuePending;
   logic        divEnd;
   logic        gapEnd;
   logic        frameActive;

`ifdef SPI_CTRL_FIFO_EN
   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PtrW:0] FifoFullCount = (PtrW + 1)'(FIFO_DEPTH);

   logic [14:0]     fifoMem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wrPtr_q, wrPtr_d;
   logic [PtrW-1:0] rdPtr_q, rdPtr_d;
   logic [PtrW:0]   count_q, count_d;
   logic            fifoFull;
   logic            fifoEmpty;
   logic            push;
   logic            pop;

   assign fifoFull     = (count_q == FifoFullCount);
   assign fifoEmpty    = (count_q == '0);
   assign req_ready    = !fifoFull;
   assign push         = req_valid && !fifoFull;
   assign pop          = (state_q == IDLE) && !fifoEmpty;
   assign start        = pop;
   assign cmdWord      = fifoMem_q[rdPtr_q];
   assign queuePending = (count_d != '0);

   // FIFO bookkeeping: pointers wrap naturally because the depth is a power of two
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (push) begin
         wrPtr_d = wrPtr_q + 1'b1;
      end
      if (pop) begin
         rdPtr_d = rdPtr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // FIFO pointer and occupancy registers; reset empties the queue
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // FIFO storage needs no reset since occupancy decides what is valid
   always_ff @(posedge clk) begin
      if (push) begin
         fifoMem_q[wrPtr_q] <= {req_addr, req_data};
      end
   end
`else
   assign req_ready    = (state_q == IDLE) && !rst;
   assign start        = req_valid && req_ready;
   assign cmdWord      = {req_addr, req_data};
   assign queuePending = 1'b0;
`endif

   assign divEnd = (div_q == DivLast);
   assign gapEnd = (div_q == GapLast);

   // Next-state logic: every phase lasts CLK_DIV cycles, the divider restarts at each phase change
   always_comb begin
      state_d    = state_q;
      div_d      = div_q + 8'd1;
      bitCnt_d   = bitCnt_q;
      shiftReg_d = shiftReg_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            div_d = '0;
            if (start) begin
               state_d    = SETUP;
               bitCnt_d   = '0;
               shiftReg_d = {1'b1, cmdWord};
            end
         end
         SETUP: begin
            if (divEnd) begin
               state_d = SHIFT_HI;
               div_d   = '0;
            end
         end
         SHIFT_HI: begin
            if (divEnd) begin
               state_d = SHIFT_LO;
               div_d   = '0;
               if (bitCnt_q != 4'd15) begin
                  shiftReg_d = {shiftReg_q[14:0], 1'b0};
               end
            end
         end
         SHIFT_LO: begin
            if (divEnd) begin
               div_d = '0;
               if (bitCnt_q == 4'd15) begin
                  state_d = GAP;
                  done_d  = 1'b1;
               end else begin
                  state_d  = SHIFT_HI;
                  bitCnt_d = bitCnt_q + 4'd1;
               end
            end
         end
         GAP: begin
            if (gapEnd) begin
               state_d = IDLE;
               div_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            div_d   = '0;
         end
      endcase
   end

   // Output look-ahead: pins are computed from the next state so they change on the same edge as the FSM
   always_comb begin
      frameActive = (state_d == SETUP) || (state_d == SHIFT_HI) || (state_d == SHIFT_LO);
      csN_d       = !frameActive;
      sclk_d      = (state_d == SHIFT_HI);
      copi_d      = frameActive ? shiftReg_d[15] : 1'b0;
      busy_d      = (state_d != IDLE) || queuePending;
   end

   // State, counters and registered SPI pins
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         div_q      <= '0;
         bitCnt_q   <= '0;
         shiftReg_q <= '0;
         csN_q      <= 1'b1;
         sclk_q     <= 1'b0;
         copi_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bitCnt_q   <= bitCnt_d;
         shiftReg_q <= shiftReg_d;
         csN_q      <= csN_d;
         sclk_q     <= sclk_d;
         copi_q     <= copi_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign cs_n = csN_q;
   assign sclk = sclk_q;
   assign copi = copi_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_spi_write_controller.sv
// tb_spi_write_controller
// Drives write commands, captures frames off the SPI pins and compares them
// with frames predicted from the command format, plus a register-file model
// fed by the captured frames.
`timescale 1ns/1ps
module tb_spi_write_controller;

   localparam int unsigned ClkDiv    = 4;
   localparam int unsigned GapCycles = 4;
   localparam int          LowCycles = 33 * ClkDiv;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [6:0] req_addr;
   logic [7:0] req_data;
   logic       cs_n;
   logic       sclk;
   logic       copi;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] word;
      int          edges;
      int          lowCnt;
      logic        doneAtRise;
      int          gapBefore;
   } frame_t;

   frame_t      capQ[$];
   logic [15:0] expQ[$];
   logic [7:0]  regModel [128];
   int          doneCount = 0;
   bit          abortPending = 1'b0;

   logic        prevCs = 1'b1;
   logic        prevSclk = 1'b0;
   logic [15:0] curWord = '0;
   int          curEdges = 0;
   int          curLow = 0;
   int          highCnt = 1000;
   int          gapRec = 1000;
   bit          inFrame = 1'b0;
   frame_t      monFrame;

   always #5 clk = ~clk;

   spi_write_controller #(
      .CLK_DIV   (ClkDiv),
      .GAP_CYCLES(GapCycles)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_addr (req_addr),
      .req_data (req_data),
      .cs_n     (cs_n),
      .sclk     (sclk),
      .copi     (copi),
      .busy     (busy),
      .done     (done)
   );

   // Pin monitor: captures bits on sclk rising edges, measures cs_n low/high
   // times and feeds completed write frames into the register-file model
   always @(negedge clk) begin
      if (done === 1'b1) doneCount++;
      if (cs_n === 1'b0) begin
         if (prevCs === 1'b1) begin
            inFrame = 1'b1;
            curWord = '0;
            curEdges = 0;
            curLow = 0;
            gapRec = highCnt;
         end
         curLow++;
         if (sclk === 1'b1 && prevSclk === 1'b0) begin
            curWord = {curWord[14:0], copi};
            curEdges++;
         end
      end else begin
         if (prevCs === 1'b0 && inFrame) begin
            if (abortPending) begin
               abortPending = 1'b0;
               highCnt = 1000;
            end else begin
               monFrame.word = curWord;
               monFrame.edges = curEdges;
               monFrame.lowCnt = curLow;
               monFrame.doneAtRise = done;
               monFrame.gapBefore = gapRec;
               capQ.push_back(monFrame);
               if (curWord[15]) regModel[curWord[14:8]] = curWord[7:0];
               highCnt = 0;
            end
            inFrame = 1'b0;
         end
         if (highCnt < 1000) highCnt++;
      end
      prevCs = cs_n;
      prevSclk = sclk;
   end

   // Presents one command and holds it until accepted; the expected frame is recorded at acceptance
   task automatic applyStimulus(input logic [6:0] a, input logic [7:0] d, input bit keepValid);
      int n = 0;
      req_valid = 1'b1;
      req_addr = a;
      req_data = d;
      while (req_ready !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         checks++; errors++;
         $display("[TB] FAIL accept_timeout: addr %h not accepted, required acceptance within 2000 cycles", a);
         req_valid = 1'b0;
      end else begin
         @(posedge clk);
         expQ.push_back({1'b1, a, d});
         @(negedge clk);
         if (!keepValid) req_valid = 1'b0;
      end
   endtask

   // Waits for n captured frames and an idle controller, bounded
   task automatic waitFrames(input int nFrames);
      int n = 0;
      while ((capQ.size() < nFrames || busy !== 1'b0) && n < 6000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 6000) begin
         checks++; errors++;
         $display("[TB] FAIL frame_timeout: got %0d frames, required %0d", capQ.size(), nFrames);
      end
   endtask

   // Reset state and 20 idle cycles afterwards
   task automatic test_reset();
      rst = 1'b1;
      req_valid = 1'b0;
      req_addr = '0;
      req_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if ({cs_n, sclk, copi, busy, done, req_ready} !== 6'b100001) begin
            errors++;
            $display("[TB] FAIL reset_idle cycle %0d: got cs_n/sclk/copi/busy/done/ready=%b, required 100001",
                     i, {cs_n, sclk, copi, busy, done, req_ready});
         end
      end
   endtask

   // Single frame addr=0x00 data=0xA5
   task automatic test_single_frame();
      frame_t f;
      logic [15:0] e;
      int doneBefore = doneCount;
      applyStimulus(7'h00, 8'hA5, 1'b0);
      waitFrames(1);
      checks++;
      if (doneCount - doneBefore !== 1) begin
         errors++;
         $display("[TB] FAIL single_done_count: got %0d, required 1", doneCount - doneBefore);
      end
      checks++;
      if (capQ.size() > 0 && capQ[0].word !== 16'h80A5) begin
         errors++;
         $display("[TB] FAIL single_word_const: got %h, required 80a5", capQ[0].word);
      end
      while (capQ.size() > 0) begin
         f = capQ.pop_front();
         e = (expQ.size() > 0) ? expQ.pop_front() : 16'hxxxx;
         checks++; if (f.word !== e) begin errors++; $display("[TB] FAIL single_word: got %h, required %h", f.word, e); end
         checks++; if (f.edges != 16) begin errors++; $display("[TB] FAIL single_edges: got %0d, required 16", f.edges); end
         checks++; if (f.lowCnt != LowCycles) begin errors++; $display("[TB] FAIL single_cs_low: got %0d, required %0d", f.lowCnt, LowCycles); end
         checks++; if (f.doneAtRise !== 1'b1) begin errors++; $display("[TB] FAIL single_done_at_rise: got %b, required 1", f.doneAtRise); end
      end
   endtask

   // Two frames back to back, the second held valid while the first is in flight
   task automatic test_back_to_back();
      frame_t f;
      logic [15:0] e;
      int n = 0;
      bit readyWhileBusy = 1'b0;
`ifdef SPI_CTRL_FIFO_EN
      applyStimulus(7'h04, 8'hFF, 1'b0);
      applyStimulus(7'h01, 8'h3C, 1'b0);
`else
      applyStimulus(7'h04, 8'hFF, 1'b1);
      req_addr = 7'h01;
      req_data = 8'h3C;
      while (busy === 1'b1 && n < 1000) begin
         if (req_ready === 1'b1) readyWhileBusy = 1'b1;
         @(negedge clk);
         n++;
      end
      checks++;
      if (readyWhileBusy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_ready_while_busy: got 1, required 0");
      end
      applyStimulus(7'h01, 8'h3C, 1'b0);
`endif
      waitFrames(2);
      checks++;
      if (capQ.size() != 2) begin
         errors++;
         $display("[TB] FAIL b2b_frame_count: got %0d, required 2", capQ.size());
      end
      while (capQ.size() > 0) begin
         f = capQ.pop_front();
         e = (expQ.size() > 0) ? expQ.pop_front() : 16'hxxxx;
         checks++; if (f.word !== e) begin errors++; $display("[TB] FAIL b2b_word: got %h, required %h", f.word, e); end
         checks++; if (f.edges != 16) begin errors++; $display("[TB] FAIL b2b_edges: got %0d, required 16", f.edges); end
         checks++; if (f.lowCnt != LowCycles) begin errors++; $display("[TB] FAIL b2b_cs_low: got %0d, required %0d", f.lowCnt, LowCycles); end
         checks++; if (f.gapBefore < GapCycles + 1) begin errors++; $display("[TB] FAIL b2b_gap: got %0d, required >= %0d", f.gapBefore, GapCycles + 1); end
      end
   endtask

   // Reset in the middle of a frame, then the same frame again
   task automatic test_reset_mid_frame();
      frame_t f;
      logic [15:0] e;
      int n = 0;
      int doneBefore;
      applyStimulus(7'h02, 8'h55, 1'b0);
      while (curEdges < 8 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      doneBefore = doneCount;
      abortPending = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({cs_n, sclk, copi, busy, done} !== 5'b10000) begin
         errors++;
         $display("[TB] FAIL midreset_pins: got cs_n/sclk/copi/busy/done=%b, required 10000", {cs_n, sclk, copi, busy, done});
      end
      rst = 1'b0;
      repeat (GapCycles + 2) @(negedge clk);
      checks++;
      if (doneCount != doneBefore || capQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL midreset_discard: got %0d done pulses and %0d frames, required 0 and 0",
                  doneCount - doneBefore, capQ.size());
      end
      if (expQ.size() > 0) void'(expQ.pop_front());
      applyStimulus(7'h02, 8'h55, 1'b0);
      waitFrames(1);
      while (capQ.size() > 0) begin
         f = capQ.pop_front();
         e = (expQ.size() > 0) ? expQ.pop_front() : 16'hxxxx;
         checks++; if (f.word !== e) begin errors++; $display("[TB] FAIL midreset_retry_word: got %h, required %h", f.word, e); end
         checks++; if (f.lowCnt != LowCycles) begin errors++; $display("[TB] FAIL midreset_retry_cs_low: got %0d, required %0d", f.lowCnt, LowCycles); end
      end
   endtask

   // Reset and req_valid together: nothing may be accepted
   task automatic test_reset_with_valid();
      int lowSeen = 0;
      rst = 1'b1;
      req_valid = 1'b1;
      req_addr = 7'h33;
      req_data = 8'h99;
      @(negedge clk);
      rst = 1'b0;
      req_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (cs_n !== 1'b1 || busy !== 1'b0) lowSeen++;
      end
      checks++;
      if (lowSeen != 0 || capQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL reset_vs_valid: got %0d active cycles and %0d frames, required 0 and 0", lowSeen, capQ.size());
      end
   endtask

   // Loopback into the register-file model: 0x11..0x15 to addresses 0..4
   task automatic test_loopback();
      logic [7:0] want;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(7'(i), 8'(8'h11 + i), 1'b0);
      end
      waitFrames(5);
      for (int i = 0; i < 5; i++) begin
         want = 8'(8'h11 + i);
         checks++;
         if (regModel[i] !== want) begin
            errors++;
            $display("[TB] FAIL loopback_reg%0d: got %h, required %h", i, regModel[i], want);
         end
      end
      capQ.delete();
      expQ.delete();
   endtask

   // Random addresses, data and idle spacing
   task automatic test_random();
      frame_t f;
      logic [15:0] e;
      int idle;
      for (int i = 0; i < 8; i++) begin
         idle = $urandom_range(0, 3);
         repeat (idle) @(negedge clk);
         applyStimulus(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)), 1'b0);
      end
      waitFrames(8);
      checks++;
      if (capQ.size() != 8) begin
         errors++;
         $display("[TB] FAIL rand_frame_count: got %0d, required 8", capQ.size());
      end
      while (capQ.size() > 0) begin
         f = capQ.pop_front();
         e = (expQ.size() > 0) ? expQ.pop_front() : 16'hxxxx;
         checks++; if (f.word !== e) begin errors++; $display("[TB] FAIL rand_word: got %h, required %h", f.word, e); end
         checks++; if (f.edges != 16) begin errors++; $display("[TB] FAIL rand_edges: got %0d, required 16", f.edges); end
         checks++; if (f.lowCnt != LowCycles) begin errors++; $display("[TB] FAIL rand_cs_low: got %0d, required %0d", f.lowCnt, LowCycles); end
         checks++; if (f.gapBefore < GapCycles + 1) begin errors++; $display("[TB] FAIL rand_gap: got %0d, required >= %0d", f.gapBefore, GapCycles + 1); end
      end
   endtask

`ifdef SPI_CTRL_FIFO_EN
   // Five queued commands: the FIFO fills, then all frames leave in order
   task automatic test_fifo();
      frame_t f;
      logic [15:0] e;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(7'(7'h10 + i), 8'($urandom_range(0, 255)), 1'b0);
      end
      checks++;
      if (req_ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL fifo_full: got ready=%b busy=%b, required ready=0 busy=1", req_ready, busy);
      end
      waitFrames(5);
      while (capQ.size() > 0) begin
         f = capQ.pop_front();
         e = (expQ.size() > 0) ? expQ.pop_front() : 16'hxxxx;
         checks++; if (f.word !== e) begin errors++; $display("[TB] FAIL fifo_word: got %h, required %h", f.word, e); end
      end
   endtask
`endif

   // Overall bound on simulation time
   initial begin
      #3_000_000;
      errors++;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Test sequence
   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_reset_mid_frame();
      test_reset_with_valid();
      test_loopback();
      test_random();
`ifdef SPI_CTRL_FIFO_EN
      test_fifo();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
